// File: rtl/dcache_refill_assembler_pkg.sv
// rtl/dcache_refill_assembler_pkg.sv - shared DCache refill constants and FSM state type
package dcache_refill_assembler_pkg;
  localparam int OFFSET_LEN = 6;
  localparam int LINE_WORDS = 1 << (OFFSET_LEN - 2);
  localparam int WORD_IDX_W = OFFSET_LEN - 2;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    OUT
  } state_e;
endpackage

// File: rtl/dcache_refill_assembler_byte_merge.sv
// rtl/dcache_refill_assembler_byte_merge.sv - combinational strobe-driven byte merge of store data over an old word
module dcache_byte_merge (
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic [31:0] old_data,
  output logic [31:0] merged
);
  always_comb begin
    merged = old_data;
    for (int k = 0; k < 4; k++) begin
      if (wstrb[k]) merged[8*k +: 8] = wdata[8*k +: 8];
    end
  end
endmodule

// File: rtl/dcache_refill_assembler.sv
// rtl/dcache_refill_assembler.sv - assembles a wrapping refill burst into one cache line
module dcache_refill_assembler
  import dcache_refill_assembler_pkg::*;
#(
  parameter int Offset_len = OFFSET_LEN
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [Offset_len-1:0]           req_offset,
  input  logic                            req_wr,
  input  logic [3:0]                      req_wstrb,
  input  logic [31:0]                     req_wdata,
  input  logic                            beat_valid,
  output logic                            beat_ready,
  input  logic [31:0]                     beat_data,
  input  logic                            beat_last,
  output logic                            crit_valid,
  output logic [31:0]                     crit_data,
  output logic                            line_valid,
  input  logic                            line_ready,
  output logic [(1<<(Offset_len+3))-1:0]  line_data,
  output logic                            err
);
  localparam int LW     = 1 << (Offset_len - 2);
  localparam int WIW    = Offset_len - 2;
  localparam int LINE_W = 1 << (Offset_len + 3);
  localparam logic [WIW-1:0] LAST_CNT = WIW'(LW - 1);

  state_e              state_q, state_d;
  logic [WIW-1:0]      cnt_q, cnt_d;
  logic [WIW-1:0]      start_q, start_d;
  logic                wr_q, wr_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                crit_valid_q, crit_valid_d;
  logic [31:0]         crit_data_q, crit_data_d;
  logic                err_q, err_d;

  logic                beat_fire;
  logic [WIW-1:0]      widx;
  logic [31:0]         merged;
  logic [31:0]         beat_word;
  logic [LW-1:0]       word_en;

  dcache_byte_merge u_merge (
    .wdata    (wdata_q),
    .wstrb    (wstrb_q),
    .old_data (beat_data),
    .merged   (merged)
  );

  // Wrap comes for free from truncating the sum to the word-index width.
  assign beat_fire = (state_q == FILL) && beat_valid;
  assign widx      = start_q + cnt_q;
  assign beat_word = (cnt_q == '0 && wr_q) ? merged : beat_data;

  always_comb begin
    word_en = '0;
    for (int i = 0; i < LW; i++) begin
      word_en[i] = beat_fire && (widx == WIW'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    start_d      = start_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    line_d       = line_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          start_d = req_offset[Offset_len-1:2];
          wr_d    = req_wr;
          wstrb_d = req_wstrb;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        for (int i = 0; i < LW; i++) begin
          if (word_en[i]) line_d[32*i +: 32] = beat_word;
        end
        if (beat_valid) begin
          if (cnt_q == '0 && !wr_q) begin
            crit_valid_d = 1'b1;
            crit_data_d  = beat_data;
          end
          // beat_last is only checked, never used to end the burst.
          err_d = beat_last != (cnt_q == LAST_CNT);
          cnt_d = cnt_q + WIW'(1);
          if (cnt_q == LAST_CNT) state_d = OUT;
        end
      end
      OUT: begin
        if (line_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      start_q      <= '0;
      wr_q         <= 1'b0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      line_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      wr_q         <= wr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      line_q       <= line_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
      err_q        <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign beat_ready = (state_q == FILL);
  assign line_valid = (state_q == OUT);
  assign line_data  = line_q;
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign err        = err_q;
endmodule

// File: tb/tb_dcache_refill_assembler.sv
// tb/tb_dcache_refill_assembler.sv - randomized self-checking bench for dcache_refill_assembler
module tb_dcache_refill_assembler;
  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid, req_ready, req_wr;
  logic [5:0]   req_offset;
  logic [3:0]   req_wstrb;
  logic [31:0]  req_wdata;
  logic         beat_valid, beat_ready, beat_last;
  logic [31:0]  beat_data;
  logic         crit_valid, line_valid, line_ready, err;
  logic [31:0]  crit_data;
  logic [511:0] line_data;

  dcache_refill_assembler #(.Offset_len(6)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_offset(req_offset),
    .req_wr(req_wr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data), .beat_last(beat_last),
    .crit_valid(crit_valid), .crit_data(crit_data),
    .line_valid(line_valid), .line_ready(line_ready), .line_data(line_data),
    .err(err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int crit_cnt = 0;
  int err_cnt = 0;
  logic [31:0] crit_last = '0;
  always @(negedge clk) begin
    if (crit_valid === 1'b1) begin
      crit_cnt  = crit_cnt + 1;
      crit_last = crit_data;
    end
    if (err === 1'b1) err_cnt = err_cnt + 1;
  end

  int passed = 0;
  int total = 0;
  int timeouts = 0;
  logic [31:0]  beat_q [16];
  int unsigned  t_req, t_end;
  logic         br_t1, lv_end, stable, rr_low, rr_after;
  logic [511:0] line_got;
  int           crit_base, err_base;

  // Expected line from the burst rules: beat n lands in word (start+n) mod 16,
  // and a store miss overlays its strobed bytes on the first beat only.
  function automatic logic [511:0] model(input logic [5:0] off, input logic wr,
                                         input logic [3:0] strb, input logic [31:0] wd);
    logic [511:0] l;
    logic [31:0]  w;
    int s;
    l = '0;
    s = int'(off) / 4;
    for (int n = 0; n < 16; n++) begin
      w = beat_q[n];
      if (n == 0 && wr) begin
        for (int k = 0; k < 4; k++) if (strb[k]) w[8*k +: 8] = wd[8*k +: 8];
      end
      l[((s + n) % 16) * 32 +: 32] = w;
    end
    return l;
  endfunction

  task automatic send_req(input logic [5:0] off, input logic wr, input logic [3:0] strb, input logic [31:0] wd);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 20) timeouts++;
    req_valid = 1'b1; req_offset = off; req_wr = wr; req_wstrb = strb; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    t_req = cyc;
    br_t1 = beat_ready;
    crit_base = crit_cnt;
    err_base = err_cnt;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last, input bit gap);
    if (gap) begin
      beat_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    beat_valid = 1'b1; beat_data = d; beat_last = last;
    @(posedge clk); #1;
    beat_valid = 1'b0; beat_last = 1'b0;
  endtask

  task automatic finish_line(input int hold);
    t_end = cyc;
    lv_end = line_valid;
    line_got = line_data;
    stable = 1'b1;
    rr_low = (req_ready === 1'b0);
    repeat (hold) begin
      @(posedge clk); #1;
      if (line_data !== line_got || line_valid !== 1'b1) stable = 1'b0;
      if (req_ready !== 1'b0) rr_low = 1'b0;
    end
    line_ready = 1'b1;
    @(posedge clk); #1;
    line_ready = 1'b0;
    rr_after = req_ready;
  endtask

  task automatic do_miss(input logic [5:0] off, input logic wr, input logic [3:0] strb, input logic [31:0] wd,
                         input bit gaps, input int last_pos, input bit drop15, input int hold);
    send_req(off, wr, strb, wd);
    for (int n = 0; n < 16; n++) begin
      send_beat(beat_q[n], (n == last_pos) || (n == 15 && !drop15), gaps && ($urandom_range(0, 2) == 0));
    end
    finish_line(hold);
  endtask

  task automatic rand_beats();
    for (int n = 0; n < 16; n++) beat_q[n] = $urandom;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #2;
    total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else passed++;
    total++; if (beat_ready !== 1'b0) $display("FAIL reset_beat_ready got %b exp 0", beat_ready); else passed++;
    total++; if (crit_valid !== 1'b0 || crit_data !== 32'h0) $display("FAIL reset_crit got %b/%h exp 0/0", crit_valid, crit_data); else passed++;
    total++; if (line_valid !== 1'b0) $display("FAIL reset_line_valid got %b exp 0", line_valid); else passed++;
    total++; if (line_data !== '0) $display("FAIL reset_line_data got %h exp 0", line_data); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passed++;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_aligned();
    for (int n = 0; n < 16; n++) beat_q[n] = 32'h1000_0000 + n;
    do_miss(6'h00, 1'b0, 4'h0, 32'h0, 1'b0, 99, 1'b0, 0);
    total++; if (br_t1 !== 1'b1) $display("FAIL aligned_beat_ready_t1 got %b exp 1", br_t1); else passed++;
    total++; if (line_got !== model(6'h00, 1'b0, 4'h0, 32'h0)) $display("FAIL aligned_line got %h exp %h", line_got, model(6'h00, 1'b0, 4'h0, 32'h0)); else passed++;
    total++; if (crit_cnt - crit_base !== 1) $display("FAIL aligned_crit_count got %0d exp 1", crit_cnt - crit_base); else passed++;
    total++; if (crit_last !== 32'h1000_0000) $display("FAIL aligned_crit_data got %h exp 10000000", crit_last); else passed++;
    total++; if (t_end - t_req !== 16 || lv_end !== 1'b1) $display("FAIL aligned_latency got %0d/%b exp 16/1", t_end - t_req, lv_end); else passed++;
    total++; if (err_cnt - err_base !== 0) $display("FAIL aligned_err got %0d exp 0", err_cnt - err_base); else passed++;
    total++; if (rr_after !== 1'b1) $display("FAIL aligned_req_ready_after got %b exp 1", rr_after); else passed++;
  endtask

  task automatic test_load_wrap();
    rand_beats();
    do_miss(6'h3C, 1'b0, 4'h0, 32'h0, 1'b0, 99, 1'b0, 0);
    total++; if (line_got[511:480] !== beat_q[0] || line_got[31:0] !== beat_q[1]) $display("FAIL wrap_words got %h/%h exp %h/%h", line_got[511:480], line_got[31:0], beat_q[0], beat_q[1]); else passed++;
    total++; if (line_got !== model(6'h3C, 1'b0, 4'h0, 32'h0)) $display("FAIL wrap_line got %h exp %h", line_got, model(6'h3C, 1'b0, 4'h0, 32'h0)); else passed++;
    total++; if (crit_cnt - crit_base !== 1 || crit_last !== beat_q[0]) $display("FAIL wrap_crit got %0d/%h exp 1/%h", crit_cnt - crit_base, crit_last, beat_q[0]); else passed++;
  endtask

  task automatic test_store_merge();
    rand_beats();
    beat_q[0] = 32'h1122_3344;
    do_miss(6'h24, 1'b1, 4'b0101, 32'hAABB_CCDD, 1'b0, 99, 1'b0, 0);
    total++; if (line_got[9*32 +: 32] !== 32'h11BB_33DD) $display("FAIL store_word9 got %h exp 11bb33dd", line_got[9*32 +: 32]); else passed++;
    total++; if (line_got !== model(6'h24, 1'b1, 4'b0101, 32'hAABB_CCDD)) $display("FAIL store_line got %h exp %h", line_got, model(6'h24, 1'b1, 4'b0101, 32'hAABB_CCDD)); else passed++;
    total++; if (crit_cnt - crit_base !== 0) $display("FAIL store_no_crit got %0d exp 0", crit_cnt - crit_base); else passed++;
  endtask

  task automatic test_zero_strobe();
    logic [5:0] off;
    rand_beats();
    off = {4'($urandom_range(0, 15)), 2'b00};
    do_miss(off, 1'b1, 4'b0000, $urandom, 1'b0, 99, 1'b0, 0);
    total++; if (line_got !== model(off, 1'b0, 4'h0, 32'h0)) $display("FAIL zero_strobe_line got %h exp %h", line_got, model(off, 1'b0, 4'h0, 32'h0)); else passed++;
    total++; if (crit_cnt - crit_base !== 0) $display("FAIL zero_strobe_crit got %0d exp 0", crit_cnt - crit_base); else passed++;
  endtask

  task automatic test_stall();
    logic [5:0] off;
    rand_beats();
    off = 6'($urandom_range(0, 63));
    do_miss(off, 1'b0, 4'h0, 32'h0, 1'b1, 99, 1'b0, 5);
    total++; if (line_got !== model(off, 1'b0, 4'h0, 32'h0)) $display("FAIL stall_line got %h exp %h", line_got, model(off, 1'b0, 4'h0, 32'h0)); else passed++;
    total++; if (lv_end !== 1'b1 || stable !== 1'b1) $display("FAIL stall_line_stable got %b/%b exp 1/1", lv_end, stable); else passed++;
    total++; if (rr_low !== 1'b1 || rr_after !== 1'b1) $display("FAIL stall_req_ready got low=%b after=%b exp 1/1", rr_low, rr_after); else passed++;
    total++; if (crit_cnt - crit_base !== 1 || crit_last !== beat_q[0]) $display("FAIL stall_crit got %0d/%h exp 1/%h", crit_cnt - crit_base, crit_last, beat_q[0]); else passed++;
  endtask

  task automatic test_beat_last();
    rand_beats();
    do_miss(6'h10, 1'b0, 4'h0, 32'h0, 1'b0, 7, 1'b1, 0);
    total++; if (err_cnt - err_base !== 2) $display("FAIL last_err_count got %0d exp 2", err_cnt - err_base); else passed++;
    total++; if (lv_end !== 1'b1 || t_end - t_req !== 16) $display("FAIL last_completion got %b/%0d exp 1/16", lv_end, t_end - t_req); else passed++;
    total++; if (line_got !== model(6'h10, 1'b0, 4'h0, 32'h0)) $display("FAIL last_line got %h exp %h", line_got, model(6'h10, 1'b0, 4'h0, 32'h0)); else passed++;
  endtask

  task automatic test_reset_midfill();
    rand_beats();
    send_req(6'h08, 1'b0, 4'h0, 32'h0);
    for (int n = 0; n < 8; n++) send_beat(beat_q[n], 1'b0, 1'b0);
    beat_valid = 1'b1; beat_data = beat_q[8];
    rstn = 1'b0;
    #1;
    beat_valid = 1'b0;
    total++; if (req_ready !== 1'b1 || beat_ready !== 1'b0 || line_valid !== 1'b0) $display("FAIL midreset_handshake got %b%b%b exp 100", req_ready, beat_ready, line_valid); else passed++;
    total++; if (crit_data !== 32'h0 || crit_valid !== 1'b0 || err !== 1'b0) $display("FAIL midreset_regs got %h/%b/%b exp 0/0/0", crit_data, crit_valid, err); else passed++;
    total++; if (line_data !== '0) $display("FAIL midreset_line got %h exp 0", line_data); else passed++;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    rand_beats();
    do_miss(6'h14, 1'b1, 4'b1100, 32'hCAFE_F00D, 1'b0, 99, 1'b0, 1);
    total++; if (line_got !== model(6'h14, 1'b1, 4'b1100, 32'hCAFE_F00D)) $display("FAIL midreset_fresh_line got %h exp %h", line_got, model(6'h14, 1'b1, 4'b1100, 32'hCAFE_F00D)); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [5:0]  off;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wd;
    for (int r = 0; r < 6; r++) begin
      rand_beats();
      off = 6'($urandom_range(0, 63));
      wr = 1'($urandom_range(0, 1));
      strb = 4'($urandom_range(0, 15));
      wd = $urandom;
      do_miss(off, wr, strb, wd, 1'b0, 99, 1'b0, 0);
      total++; if (line_got !== model(off, wr, strb, wd)) $display("FAIL b2b_line[%0d] got %h exp %h", r, line_got, model(off, wr, strb, wd)); else passed++;
      total++; if (crit_cnt - crit_base !== (wr ? 0 : 1)) $display("FAIL b2b_crit[%0d] got %0d exp %0d", r, crit_cnt - crit_base, wr ? 0 : 1); else passed++;
      total++; if (t_end - t_req !== 16 || err_cnt - err_base !== 0) $display("FAIL b2b_timing[%0d] got %0d/%0d exp 16/0", r, t_end - t_req, err_cnt - err_base); else passed++;
    end
  endtask

  initial begin
    rstn = 1'b0;
    req_valid = 1'b0; req_offset = '0; req_wr = 1'b0; req_wstrb = '0; req_wdata = '0;
    beat_valid = 1'b0; beat_data = '0; beat_last = 1'b0; line_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_load_aligned();
    test_load_wrap();
    test_store_merge();
    test_zero_strobe();
    test_stall();
    test_beat_last();
    test_reset_midfill();
    test_back_to_back();
    total++; if (timeouts !== 0) $display("FAIL req_ready_timeout got %0d exp 0", timeouts); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dcache_refill_assembler.md
# dcache_refill_assembler

Refill-side line builder for the data cache. It accepts a miss request, collects a 32-bit-per-beat wrapping burst from the bus interface, and assembles it into one full cache line. For a store miss it merges the pending store into the line, and for a load miss it forwards the critical word to the pipeline early. It then presents the finished line to the DCache data-array write port. This is the writer-side counterpart of the word-select read path: it builds the line that the read mux later slices.

## Interface
Parameters:
- Offset_len, 6, log2 of line bytes (line = 1<<(Offset_len+3) bits, 16 words at default)

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- req_valid  in  1  miss request valid
- req_ready  out  1  assembler idle, can accept a request
- req_offset  in  Offset_len  byte offset of missing access; bits [Offset_len-1:2] = critical word index
- req_wr  in  1  1 = store miss (merge), 0 = load miss (forward)
- req_wstrb  in  4  store byte strobes
- req_wdata  in  32  store data
- beat_valid  in  1  refill beat valid
- beat_ready  out  1  assembler accepts beat
- beat_data  in  32  refill beat data
- beat_last  in  1  bus marks final beat
- crit_valid  out  1  one-cycle pulse: critical word available (loads only)
- crit_data  out  32  critical word, raw from bus
- line_valid  out  1  assembled line valid
- line_ready  in  1  data array accepts line
- line_data  out  1<<(Offset_len+3)  assembled line, word i at bits [32i+31:32i]
- err  out  1  one-cycle pulse on beat_last protocol mismatch

## Operation
- States: IDLE, FILL, OUT.
- IDLE:
  - req_ready=1.
  - On req_valid: latch start=req_offset[Offset_len-1:2], req_wr, req_wstrb, req_wdata; clear cnt; go to FILL.
- FILL:
  - beat_ready=1.
  - Each accepted beat writes word (start+cnt) mod 16, wrap by natural truncation to Offset_len-2 bits, then cnt++.
  - Critical beat (cnt==0), req_wr=1: byte k of the stored word = req_wstrb[k] ? req_wdata byte k : beat_data byte k.
  - Critical beat, req_wr=0: stored unmodified; crit_data registered, crit_valid pulses next cycle.
  - Beat with cnt==15 moves to OUT regardless of beat_last.
- beat_last checking:
  - beat_last=1 when cnt!=15: err pulses, beat still consumed, FILL continues.
  - beat_last=0 when cnt==15: err pulses, transition still taken.
  - The assembler counts beats itself and never trusts beat_last for sequencing.
- OUT:
  - line_valid=1, line_data stable until line_ready.
  - On line_ready: go to IDLE.
- Strobes all zero on a store miss: behaves as a pure refill, no crit pulse.

## Timing
- Reset values: req_ready=1, beat_ready=0, crit_valid=0, crit_data=0, line_valid=0, line_data=0, err=0, state=IDLE, cnt=0.
- Outputs registered except req_ready, beat_ready and line_valid, which decode state directly.
- Request accepted in cycle T: beat_ready high from T+1.
- Back-to-back beats: last beat accepted T+16, line_valid high T+17.
- crit_valid is high exactly one cycle, the cycle after the critical beat's handshake.
- err is high the cycle after the offending beat.
- OUT→IDLE on the line_ready cycle; req_ready high the next cycle. There is no same-cycle request bypass, so at most one miss is in flight.
- Gaps in beat_valid simply stall cnt, with no timeout.
- Reset mid-FILL or mid-OUT: immediate return to IDLE with all outputs at reset values. Any partial line is discarded, and subsequent beats of the aborted burst are the bus side's responsibility.
- req_valid outside IDLE is ignored (req_ready=0).

## Structure
- Shared DCache package holds:
  - LINE_WORDS = 1<<(Offset_len-2)
  - WORD_IDX_W = Offset_len-2
  - state enum {IDLE, FILL, OUT}
- One sub-module: dcache_byte_merge (32-bit data, 4-bit strobe, 32-bit old → 32-bit merged). It is combinational and also reusable by the store-hit path.
- Line buffer: one register of line width written one word per beat via decoded word-enable.

## Test plan
- Load miss, req_offset=0x00, beats 0x1000_0000+i back-to-back: line word i = 0x1000_0000+i; crit_valid pulses once with crit_data=0x1000_0000; line_valid at T+17.
- Load miss, req_offset=0x3C (word 15): first beat lands in word 15, second in word 0 (wrap); crit_data = first beat; full line correct.
- Store miss, req_offset=0x24 (word 9), wstrb=4'b0101, wdata=0xAABBCCDD, critical beat 0x11223344: word 9 = 0x11BB33DD; crit_valid never asserts.
- Random beat_valid gaps and line_ready held low 5 cycles: line_data stable through stall; req_ready low until the cycle after line_ready.
- beat_last asserted on beat 7 and absent on beat 15: err pulses twice; line still complete after 16 beats.
- rstn dropped at beat 8 then released: all outputs at reset values immediately; a fresh request completes a correct line.
